// File: rtl/id_ex_stage_pkg.sv
// Shared core types for the ID/EX boundary: opcodes, writeback selector, the
// ID/EX register bundle, its bubble value and the register-usage decode.
package id_ex_stage_pkg;

    typedef enum logic [1:0] {
        NO_WRITEBACK = 2'd0,
        WB_ALU       = 2'd1,
        WB_MEM       = 2'd2,
        WB_PC4       = 2'd3
    } write_back_mux_selector;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic                   valid;
        logic [6:0]             opcode;
        logic [4:0]             rs1;
        logic [4:0]             rs2;
        logic [4:0]             rd;
        logic [31:0]            rs1_data;
        logic [31:0]            rs2_data;
        logic [31:0]            imm;
        logic [31:0]            pc;
        write_back_mux_selector wb_mux;
        logic [7:0]             ctrl;
    } id_ex_bundle_t;

    // Opcode 0 matches no register-using opcode, so a bubble never forwards.
    localparam id_ex_bundle_t ID_EX_BUBBLE = '{
        valid:    1'b0,
        opcode:   7'b0,
        rs1:      5'd0,
        rs2:      5'd0,
        rd:       5'd0,
        rs1_data: 32'd0,
        rs2_data: 32'd0,
        imm:      32'd0,
        pc:       32'd0,
        wb_mux:   NO_WRITEBACK,
        ctrl:     8'd0
    };

    function automatic logic uses_rs1(input logic [6:0] opcode);
        case (opcode)
            OPCODE_OP, OPCODE_OPIMM, OPCODE_LOAD,
            OPCODE_STORE, OPCODE_BRANCH, OPCODE_JALR: uses_rs1 = 1'b1;
            default:                                  uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        case (opcode)
            OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH: uses_rs2 = 1'b1;
            default:                                uses_rs2 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard check: a valid load in EX whose destination
// is read by the valid instruction in ID.
import id_ex_stage_pkg::*;

module load_use_detect (
    input  logic       i_id_valid,
    input  logic [6:0] i_id_opcode,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_ex_valid,
    input  logic [6:0] i_ex_opcode,
    input  logic [4:0] i_ex_rd,
    output logic       o_lu
);

    logic w_ex_is_load;
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_ex_is_load = i_ex_valid && (i_ex_opcode == OPCODE_LOAD) && (i_ex_rd != 5'd0);
    assign w_rs1_hit    = uses_rs1(i_id_opcode) && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit    = uses_rs2(i_id_opcode) && (i_id_rs2 == i_ex_rd);
    assign o_lu         = i_id_valid && w_ex_is_load && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, redirect flush and
// saturating hazard event counters.
import id_ex_stage_pkg::*;

module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_stall_ip,
    input  logic                   ex_redirect_ip,
    input  logic                   id_valid_ip,
    input  logic [6:0]             id_instr_opcode_ip,
    input  logic [4:0]             id_rs1_ip,
    input  logic [4:0]             id_rs2_ip,
    input  logic [4:0]             id_rd_ip,
    input  logic [31:0]            id_rs1_data_ip,
    input  logic [31:0]            id_rs2_data_ip,
    input  logic [31:0]            id_imm_ip,
    input  logic [31:0]            id_pc_ip,
    input  write_back_mux_selector id_wb_mux_ip,
    input  logic [7:0]             id_ctrl_ip,
    output logic                   ex_valid_op,
    output logic [6:0]             ex_opcode_op,
    output logic [4:0]             ex_rs1_op,
    output logic [4:0]             ex_rs2_op,
    output logic [4:0]             ex_rd_op,
    output logic [31:0]            ex_rs1_data_op,
    output logic [31:0]            ex_rs2_data_op,
    output logic [31:0]            ex_imm_op,
    output logic [31:0]            ex_pc_op,
    output write_back_mux_selector ex_wb_mux_op,
    output logic [7:0]             ex_ctrl_op,
    output logic                   stall_op,
    output logic [CNT_W-1:0]       load_use_cnt_op,
    output logic [CNT_W-1:0]       redirect_cnt_op
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    id_ex_bundle_t    r_ex;
    id_ex_bundle_t    w_capture;
    logic             w_lu;
    logic [CNT_W-1:0] r_load_use_cnt;
    logic [CNT_W-1:0] r_redirect_cnt;

    load_use_detect u_load_use_detect (
        .i_id_valid  (id_valid_ip),
        .i_id_opcode (id_instr_opcode_ip),
        .i_id_rs1    (id_rs1_ip),
        .i_id_rs2    (id_rs2_ip),
        .i_ex_valid  (r_ex.valid),
        .i_ex_opcode (r_ex.opcode),
        .i_ex_rd     (r_ex.rd),
        .o_lu        (w_lu)
    );

    // An invalid ID slot is captured as-is but must never write back.
    always_comb begin
        w_capture          = ID_EX_BUBBLE;
        w_capture.valid    = id_valid_ip;
        w_capture.opcode   = id_instr_opcode_ip;
        w_capture.rs1      = id_rs1_ip;
        w_capture.rs2      = id_rs2_ip;
        w_capture.rd       = id_rd_ip;
        w_capture.rs1_data = id_rs1_data_ip;
        w_capture.rs2_data = id_rs2_data_ip;
        w_capture.imm      = id_imm_ip;
        w_capture.pc       = id_pc_ip;
        w_capture.wb_mux   = id_valid_ip ? id_wb_mux_ip : NO_WRITEBACK;
        w_capture.ctrl     = id_ctrl_ip;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex           <= ID_EX_BUBBLE;
            r_load_use_cnt <= '0;
            r_redirect_cnt <= '0;
        end else if (!mem_stall_ip) begin
            if (ex_redirect_ip) begin
                r_ex <= ID_EX_BUBBLE;
                if (r_redirect_cnt != CNT_MAX) r_redirect_cnt <= r_redirect_cnt + 1'b1;
            end else if (w_lu) begin
                r_ex <= ID_EX_BUBBLE;
                if (r_load_use_cnt != CNT_MAX) r_load_use_cnt <= r_load_use_cnt + 1'b1;
            end else begin
                r_ex <= w_capture;
            end
        end
    end

    // A redirect squashes the ID instruction, so its hazard must not stall.
    assign stall_op = mem_stall_ip | (w_lu & ~ex_redirect_ip);

    assign ex_valid_op     = r_ex.valid;
    assign ex_opcode_op    = r_ex.opcode;
    assign ex_rs1_op       = r_ex.rs1;
    assign ex_rs2_op       = r_ex.rs2;
    assign ex_rd_op        = r_ex.rd;
    assign ex_rs1_data_op  = r_ex.rs1_data;
    assign ex_rs2_data_op  = r_ex.rs2_data;
    assign ex_imm_op       = r_ex.imm;
    assign ex_pc_op        = r_ex.pc;
    assign ex_wb_mux_op    = r_ex.wb_mux;
    assign ex_ctrl_op      = r_ex.ctrl;
    assign load_use_cnt_op = r_load_use_cnt;
    assign redirect_cnt_op = r_redirect_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, load-use bubbles, redirect flush,
// memory freeze, counter saturation and asynchronous reset.
import id_ex_stage_pkg::*;

module tb_id_ex_stage;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   mem_stall_ip;
    logic                   ex_redirect_ip;
    logic                   id_valid_ip;
    logic [6:0]             id_instr_opcode_ip;
    logic [4:0]             id_rs1_ip, id_rs2_ip, id_rd_ip;
    logic [31:0]            id_rs1_data_ip, id_rs2_data_ip, id_imm_ip, id_pc_ip;
    write_back_mux_selector id_wb_mux_ip;
    logic [7:0]             id_ctrl_ip;
    logic                   ex_valid_op;
    logic [6:0]             ex_opcode_op;
    logic [4:0]             ex_rs1_op, ex_rs2_op, ex_rd_op;
    logic [31:0]            ex_rs1_data_op, ex_rs2_data_op, ex_imm_op, ex_pc_op;
    write_back_mux_selector ex_wb_mux_op;
    logic [7:0]             ex_ctrl_op;
    logic                   stall_op;
    logic [CNT_W-1:0]       load_use_cnt_op, redirect_cnt_op;

    int errors = 0;
    int checks = 0;
    logic [CNT_W-1:0] exp_lu = '0;
    logic [CNT_W-1:0] exp_rd = '0;

    always #5 clk = ~clk;

    id_ex_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .mem_stall_ip(mem_stall_ip), .ex_redirect_ip(ex_redirect_ip),
        .id_valid_ip(id_valid_ip), .id_instr_opcode_ip(id_instr_opcode_ip),
        .id_rs1_ip(id_rs1_ip), .id_rs2_ip(id_rs2_ip), .id_rd_ip(id_rd_ip),
        .id_rs1_data_ip(id_rs1_data_ip), .id_rs2_data_ip(id_rs2_data_ip),
        .id_imm_ip(id_imm_ip), .id_pc_ip(id_pc_ip), .id_wb_mux_ip(id_wb_mux_ip),
        .id_ctrl_ip(id_ctrl_ip), .ex_valid_op(ex_valid_op), .ex_opcode_op(ex_opcode_op),
        .ex_rs1_op(ex_rs1_op), .ex_rs2_op(ex_rs2_op), .ex_rd_op(ex_rd_op),
        .ex_rs1_data_op(ex_rs1_data_op), .ex_rs2_data_op(ex_rs2_data_op),
        .ex_imm_op(ex_imm_op), .ex_pc_op(ex_pc_op), .ex_wb_mux_op(ex_wb_mux_op),
        .ex_ctrl_op(ex_ctrl_op), .stall_op(stall_op),
        .load_use_cnt_op(load_use_cnt_op), .redirect_cnt_op(redirect_cnt_op)
    );

    task automatic drive_id(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                            input write_back_mux_selector wb);
        id_valid_ip        = v;
        id_instr_opcode_ip = op;
        id_rs1_ip          = rs1;
        id_rs2_ip          = rs2;
        id_rd_ip           = rd;
        id_rs1_data_ip     = 32'hA000_0000 | {27'd0, rs1};
        id_rs2_data_ip     = 32'hB000_0000 | {27'd0, rs2};
        id_imm_ip          = imm;
        id_pc_ip           = 32'h0000_1000 + {25'd0, op};
        id_ctrl_ip         = {rd[3:0], 4'h5};
        id_wb_mux_ip       = wb;
        #1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Puts LW x<rd>,0(x1) into EX.
    task automatic load_into_ex(input logic [4:0] rd);
        drive_id(1'b1, OPCODE_LOAD, 5'd1, 5'd0, rd, 32'd0, WB_MEM);
        step();
    endtask

    task automatic test_reset;
        reset = 1'b0; mem_stall_ip = 1'b0; ex_redirect_ip = 1'b0;
        drive_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, NO_WRITEBACK);
        #20;
        checks++; if (ex_valid_op !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ex_valid_op); end
        checks++; if (ex_wb_mux_op !== NO_WRITEBACK) begin errors++; $display("FAIL reset_wb: got %0d want 0", ex_wb_mux_op); end
        checks++; if (stall_op !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_op); end
        checks++; if (load_use_cnt_op !== 8'd0 || redirect_cnt_op !== 8'd0) begin errors++;
            $display("FAIL reset_cnt: got lu=%0d rd=%0d want 0 0", load_use_cnt_op, redirect_cnt_op); end
        @(negedge clk); reset = 1'b1;
        step();
    endtask

    task automatic test_capture;
        drive_id(1'b1, OPCODE_OPIMM, 5'd0, 5'd7, 5'd5, 32'd7, WB_ALU);
        step();
        checks++; if (ex_valid_op !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", ex_valid_op); end
        checks++; if (ex_rd_op !== 5'd5) begin errors++; $display("FAIL addi_rd: got %0d want 5", ex_rd_op); end
        checks++; if (ex_imm_op !== 32'd7) begin errors++; $display("FAIL addi_imm: got %h want 7", ex_imm_op); end
        checks++; if (ex_pc_op !== 32'h0000_1013 || ex_ctrl_op !== 8'h55 || ex_wb_mux_op !== WB_ALU) begin errors++;
            $display("FAIL addi_fields: got pc=%h ctrl=%h wb=%0d want 00001013 55 1", ex_pc_op, ex_ctrl_op, ex_wb_mux_op); end
        checks++; if (ex_rs1_data_op !== 32'hA000_0000 || ex_rs2_data_op !== 32'hB000_0007) begin errors++;
            $display("FAIL addi_data: got %h %h want a0000000 b0000007", ex_rs1_data_op, ex_rs2_data_op); end
    endtask

    task automatic test_load_use;
        load_into_ex(5'd6);
        drive_id(1'b1, OPCODE_OP, 5'd6, 5'd2, 5'd7, 32'd0, WB_ALU);
        checks++; if (stall_op !== 1'b1) begin errors++; $display("FAIL lu_rs1_stall: got %b want 1", stall_op); end
        step(); exp_lu++;
        checks++; if (ex_valid_op !== 1'b0 || ex_opcode_op !== 7'd0 || ex_rd_op !== 5'd0) begin errors++;
            $display("FAIL lu_bubble: got v=%b op=%h rd=%0d want 0 0 0", ex_valid_op, ex_opcode_op, ex_rd_op); end
        checks++; if (stall_op !== 1'b0) begin errors++; $display("FAIL lu_after_stall: got %b want 0", stall_op); end
        checks++; if (load_use_cnt_op !== exp_lu) begin errors++; $display("FAIL lu_cnt: got %0d want %0d", load_use_cnt_op, exp_lu); end
        step();
        checks++; if (ex_valid_op !== 1'b1 || ex_rd_op !== 5'd7 || ex_opcode_op !== OPCODE_OP) begin errors++;
            $display("FAIL lu_add_enters: got v=%b rd=%0d op=%h want 1 7 33", ex_valid_op, ex_rd_op, ex_opcode_op); end
        // rs2 hit via a store
        load_into_ex(5'd6);
        drive_id(1'b1, OPCODE_STORE, 5'd2, 5'd6, 5'd0, 32'd4, NO_WRITEBACK);
        checks++; if (stall_op !== 1'b1) begin errors++; $display("FAIL lu_rs2_stall: got %b want 1", stall_op); end
        step(); exp_lu++;
        checks++; if (load_use_cnt_op !== exp_lu) begin errors++; $display("FAIL lu_rs2_cnt: got %0d want %0d", load_use_cnt_op, exp_lu); end
    endtask

    task automatic test_no_hazard;
        load_into_ex(5'd6);
        drive_id(1'b1, OPCODE_OPIMM, 5'd2, 5'd6, 5'd7, 32'd1, WB_ALU);
        checks++; if (stall_op !== 1'b0) begin errors++; $display("FAIL addi_rs2_field: got %b want 0", stall_op); end
        step();
        checks++; if (ex_valid_op !== 1'b1 || ex_rd_op !== 5'd7 || load_use_cnt_op !== exp_lu) begin errors++;
            $display("FAIL addi_no_bubble: got v=%b rd=%0d cnt=%0d want 1 7 %0d", ex_valid_op, ex_rd_op, load_use_cnt_op, exp_lu); end
        load_into_ex(5'd0);
        drive_id(1'b1, OPCODE_OP, 5'd0, 5'd2, 5'd7, 32'd0, WB_ALU);
        checks++; if (stall_op !== 1'b0) begin errors++; $display("FAIL lw_x0_stall: got %b want 0", stall_op); end
        load_into_ex(5'd6);
        drive_id(1'b0, OPCODE_OP, 5'd6, 5'd6, 5'd4, 32'h55, WB_ALU);
        checks++; if (stall_op !== 1'b0) begin errors++; $display("FAIL invalid_id_stall: got %b want 0", stall_op); end
        step();
        checks++; if (ex_valid_op !== 1'b0 || ex_wb_mux_op !== NO_WRITEBACK || ex_rd_op !== 5'd4 || ex_imm_op !== 32'h55) begin errors++;
            $display("FAIL invalid_capture: got v=%b wb=%0d rd=%0d imm=%h want 0 0 4 55", ex_valid_op, ex_wb_mux_op, ex_rd_op, ex_imm_op); end
    endtask

    task automatic test_redirect;
        load_into_ex(5'd6);
        drive_id(1'b1, OPCODE_BRANCH, 5'd6, 5'd3, 5'd0, 32'd16, NO_WRITEBACK);
        ex_redirect_ip = 1'b1; #1;
        checks++; if (stall_op !== 1'b0) begin errors++; $display("FAIL redirect_stall: got %b want 0", stall_op); end
        step(); exp_rd++;
        ex_redirect_ip = 1'b0;
        checks++; if (ex_valid_op !== 1'b0 || ex_opcode_op !== 7'd0) begin errors++;
            $display("FAIL redirect_bubble: got v=%b op=%h want 0 0", ex_valid_op, ex_opcode_op); end
        checks++; if (redirect_cnt_op !== exp_rd || load_use_cnt_op !== exp_lu) begin errors++;
            $display("FAIL redirect_cnts: got rd=%0d lu=%0d want %0d %0d", redirect_cnt_op, load_use_cnt_op, exp_rd, exp_lu); end
    endtask

    task automatic test_mem_stall;
        drive_id(1'b1, OPCODE_OPIMM, 5'd1, 5'd0, 5'd9, 32'd3, WB_ALU);
        step();
        drive_id(1'b1, OPCODE_STORE, 5'd9, 5'd6, 5'd0, 32'd4, NO_WRITEBACK);
        mem_stall_ip = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (stall_op !== 1'b1) begin errors++; $display("FAIL freeze_stall[%0d]: got %b want 1", i, stall_op); end
            step();
            checks++; if (ex_rd_op !== 5'd9 || ex_opcode_op !== OPCODE_OPIMM || ex_valid_op !== 1'b1) begin errors++;
                $display("FAIL freeze_hold[%0d]: got rd=%0d op=%h want 9 13", i, ex_rd_op, ex_opcode_op); end
        end
        checks++; if (load_use_cnt_op !== exp_lu || redirect_cnt_op !== exp_rd) begin errors++;
            $display("FAIL freeze_cnts: got lu=%0d rd=%0d want %0d %0d", load_use_cnt_op, redirect_cnt_op, exp_lu, exp_rd); end
        mem_stall_ip = 1'b0;
        step();
        checks++; if (ex_opcode_op !== OPCODE_STORE || ex_rs2_op !== 5'd6) begin errors++;
            $display("FAIL freeze_release: got op=%h rs2=%0d want 23 6", ex_opcode_op, ex_rs2_op); end
        // freeze and redirect together: hold, then flush once the freeze drops
        load_into_ex(5'd6);
        drive_id(1'b1, OPCODE_OP, 5'd6, 5'd2, 5'd7, 32'd0, WB_ALU);
        mem_stall_ip = 1'b1; ex_redirect_ip = 1'b1;
        step();
        checks++; if (ex_opcode_op !== OPCODE_LOAD || redirect_cnt_op !== exp_rd || load_use_cnt_op !== exp_lu) begin errors++;
            $display("FAIL freeze_redirect: got op=%h rd=%0d lu=%0d want 03 %0d %0d", ex_opcode_op, redirect_cnt_op, load_use_cnt_op, exp_rd, exp_lu); end
        mem_stall_ip = 1'b0;
        step(); exp_rd++;
        ex_redirect_ip = 1'b0;
        checks++; if (ex_valid_op !== 1'b0 || redirect_cnt_op !== exp_rd || load_use_cnt_op !== exp_lu) begin errors++;
            $display("FAIL redirect_over_lu: got v=%b rd=%0d lu=%0d want 0 %0d %0d", ex_valid_op, redirect_cnt_op, load_use_cnt_op, exp_rd, exp_lu); end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 300; i++) begin
            load_into_ex(5'd6);
            drive_id(1'b1, OPCODE_OP, 5'd6, 5'd2, 5'd7, 32'd0, WB_ALU);
            step();
            if (exp_lu != SAT) exp_lu++;
        end
        checks++; if (load_use_cnt_op !== SAT) begin errors++; $display("FAIL lu_saturate: got %h want %h", load_use_cnt_op, SAT); end
        load_into_ex(5'd6);
        drive_id(1'b1, OPCODE_OP, 5'd6, 5'd2, 5'd7, 32'd0, WB_ALU);
        checks++; if (stall_op !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %b want 1", stall_op); end
        reset = 1'b0; #1;
        checks++; if (load_use_cnt_op !== 8'd0 || redirect_cnt_op !== 8'd0) begin errors++;
            $display("FAIL async_reset_cnt: got lu=%0d rd=%0d want 0 0", load_use_cnt_op, redirect_cnt_op); end
        checks++; if (ex_valid_op !== 1'b0 || stall_op !== 1'b0) begin errors++;
            $display("FAIL async_reset_stall: got v=%b stall=%b want 0 0", ex_valid_op, stall_op); end
        @(negedge clk); reset = 1'b1;
        exp_lu = '0; exp_rd = '0;
    endtask

    task automatic test_back_to_back;
        drive_id(1'b1, OPCODE_LUI, 5'd0, 5'd0, 5'd10, 32'h1234_5000, WB_ALU);
        step();
        drive_id(1'b1, OPCODE_JAL, 5'd0, 5'd0, 5'd1, 32'd8, WB_PC4);
        step();
        checks++; if (ex_rd_op !== 5'd1 || ex_wb_mux_op !== WB_PC4 || ex_imm_op !== 32'd8) begin errors++;
            $display("FAIL b2b_jal: got rd=%0d wb=%0d imm=%h want 1 3 8", ex_rd_op, ex_wb_mux_op, ex_imm_op); end
        drive_id(1'b1, OPCODE_JALR, 5'd10, 5'd0, 5'd0, 32'd0, NO_WRITEBACK);
        checks++; if (stall_op !== 1'b0) begin errors++; $display("FAIL b2b_no_load: got %b want 0", stall_op); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_load_use();
        test_no_hazard();
        test_redirect();
        test_mem_stall();
        test_saturation();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the 5-stage RV32I core, combined with load-use hazard detection and control-hazard flush. It captures decoded instruction state from ID each cycle and presents it to EX and to the forwarding controller. When a load in EX feeds the instruction in ID, it inserts a one-cycle bubble. It also squashes the ID instruction on an EX redirect and keeps saturating hazard counters.

## Interface
Parameters:
- CNT_W, 16, width of each hazard event counter

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-low reset
- mem_stall_ip  input  1  global pipeline freeze (memory wait)
- ex_redirect_ip  input  1  branch/jump resolved taken in EX; flush ID
- id_valid_ip  input  1  ID holds a real instruction
- id_instr_opcode_ip  input  7  ID opcode
- id_rs1_ip, id_rs2_ip, id_rd_ip  input  5 each  ID register indices
- id_rs1_data_ip, id_rs2_data_ip  input  32 each  register file read data
- id_imm_ip, id_pc_ip  input  32 each  immediate, PC
- id_wb_mux_ip  input  write_back_mux_selector  writeback source
- id_ctrl_ip  input  8  opaque ALU/memory control bits, carried unmodified
- ex_valid_op, ex_opcode_op, ex_rs1_op, ex_rs2_op, ex_rd_op, ex_rs1_data_op, ex_rs2_data_op, ex_imm_op, ex_pc_op, ex_wb_mux_op, ex_ctrl_op  output  matching widths  registered ID/EX contents
- stall_op  output  1  hold PC and IF/ID this cycle
- load_use_cnt_op, redirect_cnt_op  output  CNT_W each  saturating event counters

## Operation
- Register usage:
  - rs1 is used by OP, OPIMM, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by OP, STORE, BRANCH.
  - All other opcodes use no registers.
- Load-use (combinational): lu = id_valid_ip & ex_valid_op & (ex_opcode_op==OPCODE_LOAD) & ex_rd_op!=0 & ((uses_rs1 & id_rs1_ip==ex_rd_op) | (uses_rs2 & id_rs2_ip==ex_rd_op)).
- Per-edge update, in priority order:
  1. mem_stall_ip=1: ID/EX holds; counters hold.
  2. ex_redirect_ip=1: load a bubble; redirect_cnt +1.
  3. lu=1: load a bubble; load_use_cnt +1.
  4. Otherwise: capture all id_* inputs.
- Bubble contents:
  - ex_valid 0, opcode 7'b0, wb_mux NO_WRITEBACK.
  - rd, rs1, rs2 = 0; data, imm, pc, ctrl = 0.
  - Because opcode is 0, no forwarding is triggered from a bubble.
- If id_valid_ip=0 on a normal capture, ex_valid=0 and the rest are captured as-is, except wb_mux, which is forced to NO_WRITEBACK.
- stall_op = mem_stall_ip | (lu & ~ex_redirect_ip). A redirect kills the wrong-path ID instruction, so it never stalls.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous assert, synchronous release effect): all ex_* outputs take bubble values, counters are 0, and stall_op is 0 (ex_valid=0, mem_stall_ip=0).
- Latency: ID to EX is 1 cycle. A load-use stall lasts exactly 1 cycle. After it, the load sits in EX/MEM→MEM/WB and the forwarding controller supplies the value by WB forwarding.
- stall_op is combinational from the current ex_* registers and the id_* inputs. Upstream samples it on the same edge.
- Simultaneous events:
  - mem_stall with redirect: freeze. Upstream holds ex_redirect_ip asserted until the freeze releases.
  - redirect with lu: bubble counted as redirect only.
- Reset asserted mid-stall: the bubble state is entered immediately and stall_op drops once ex_valid=0.

## Structure
- CORE_PKG gains:
  - id_ex_bundle_t, a packed struct of all ex_* fields.
  - ID_EX_BUBBLE, the bubble constant.
  - uses_rs1/uses_rs2 opcode functions, shared with the forwarding controller.
- One sub-module: load_use_detect, purely combinational, producing lu.
- The stage itself owns the register, priority mux and counters.

## Test plan
- After reset: ex_valid=0, ex_wb_mux=NO_WRITEBACK, stall_op=0, both counters 0. Feed ADDI x5,x0,7 → next cycle ex_rd=5, ex_imm=7, ex_valid=1.
- LW x6,0(x1) in EX, ADD x7,x6,x2 in ID → stall_op=1 that cycle. Next cycle: bubble in EX, ADD still in ID, stall_op=0, load_use_cnt=1.
- LW x6 in EX, ADDI x7,x2,1 in ID (x6 not used) → stall_op=0, no bubble. Same test with LW x0 → no stall.
- LW x6 in EX, BEQ x6,x3 in ID, ex_redirect_ip=1 → stall_op=0, bubble, redirect_cnt=1, load_use_cnt unchanged.
- mem_stall_ip=1 for 3 cycles with SW in ID → ex_* unchanged, stall_op=1, counters frozen.
- Force 70000 load-use events with CNT_W=16 → load_use_cnt saturates at 16'hFFFF. Reset mid-count → counter goes to 0 asynchronously.
